// File: rtl/vx_commit_writeback.sv
// vx_commit_writeback
//   Collects completed results from the execute units and serialises them
//   into one registered writeback stream for the GPR stage and scoreboard.
//   Sources are picked round-robin. Once a source starts a multi-beat result
//   (eop=0), it keeps the grant until its eop beat.
//
// Ports
//   clk, reset        clock; asynchronous active-low reset
//   req_valid/ready   per-source commit handshake (source i at bit i)
//   req_wid/tmask/PC/rd/data  per-source payload, source i at slice i
//   req_wb            1 = beat writes the register file, 0 = beat is dropped
//   req_eop           last beat of the instruction's result
//   wb_valid/ready    writeback handshake
//   wb_wid/tmask/PC/rd/data/eop  registered writeback payload
module vx_commit_writeback #(
   parameter int NUM_REQS    = 5,
   parameter int NUM_THREADS = 4,
   parameter int NW_BITS     = 2,
   parameter int PC_WIDTH    = 32,
   parameter int RD_BITS     = 5,
   parameter int DATA_WIDTH  = 32
) (
   input  logic                                   clk,
   input  logic                                   reset,
   input  logic [NUM_REQS-1:0]                    req_valid,
   input  logic [NUM_REQS*NW_BITS-1:0]            req_wid,
   input  logic [NUM_REQS*NUM_THREADS-1:0]        req_tmask,
   input  logic [NUM_REQS*PC_WIDTH-1:0]           req_PC,
   input  logic [NUM_REQS*RD_BITS-1:0]            req_rd,
   input  logic [NUM_REQS-1:0]                    req_wb,
   input  logic [NUM_REQS*NUM_THREADS*DATA_WIDTH-1:0] req_data,
   input  logic [NUM_REQS-1:0]                    req_eop,
   output logic [NUM_REQS-1:0]                    req_ready,
   output logic                                   wb_valid,
   input  logic                                   wb_ready,
   output logic [NW_BITS-1:0]                     wb_wid,
   output logic [NUM_THREADS-1:0]                 wb_tmask,
   output logic [PC_WIDTH-1:0]                    wb_PC,
   output logic [RD_BITS-1:0]                     wb_rd,
   output logic [NUM_THREADS*DATA_WIDTH-1:0]      wb_data,
   output logic                                   wb_eop
);

   localparam int IDX_W = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;
   localparam int DW    = NUM_THREADS * DATA_WIDTH;
   localparam logic [IDX_W:0] NUM_REQS_W = (IDX_W+1)'(NUM_REQS);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQS - 1);

   // Per-source views of the flattened payload buses
   logic [NW_BITS-1:0]     src_wid   [NUM_REQS];
   logic [NUM_THREADS-1:0] src_tmask [NUM_REQS];
   logic [PC_WIDTH-1:0]    src_pc    [NUM_REQS];
   logic [RD_BITS-1:0]     src_rd    [NUM_REQS];
   logic [DW-1:0]          src_data  [NUM_REQS];

   logic                   wb_valid_q, wb_valid_d;
   logic [NW_BITS-1:0]     wb_wid_q,   wb_wid_d;
   logic [NUM_THREADS-1:0] wb_tmask_q, wb_tmask_d;
   logic [PC_WIDTH-1:0]    wb_pc_q,    wb_pc_d;
   logic [RD_BITS-1:0]     wb_rd_q,    wb_rd_d;
   logic [DW-1:0]          wb_data_q,  wb_data_d;
   logic                   wb_eop_q,   wb_eop_d;
   logic [IDX_W-1:0]       rr_ptr_q,   rr_ptr_d;
   logic                   lock_q,     lock_d;
   logic [IDX_W-1:0]       lock_idx_q, lock_idx_d;

   logic [IDX_W-1:0]       grant_idx;
   logic                   grant_any;
   logic [IDX_W:0]         cand;
   logic                   out_free;
   logic                   fire;

   // The output register can take a beat when empty or being drained now.
   assign out_free = !wb_valid_q || wb_ready;
   // Gating with reset keeps every source stalled while reset is held.
   assign fire     = grant_any && out_free && reset;

   for (genvar gi = 0; gi < NUM_REQS; gi++) begin : g_src
      assign src_wid[gi]   = req_wid[gi*NW_BITS +: NW_BITS];
      assign src_tmask[gi] = req_tmask[gi*NUM_THREADS +: NUM_THREADS];
      assign src_pc[gi]    = req_PC[gi*PC_WIDTH +: PC_WIDTH];
      assign src_rd[gi]    = req_rd[gi*RD_BITS +: RD_BITS];
      assign src_data[gi]  = req_data[gi*DW +: DW];
      assign req_ready[gi] = fire && (grant_idx == IDX_W'(gi));
   end

   // Grant selection. Scanning the offsets from highest to lowest lets the
   // source closest to rr_ptr overwrite the others, giving the first valid
   // source at or after rr_ptr.
   always_comb begin
      grant_idx = '0;
      grant_any = 1'b0;
      cand      = '0;
      if (lock_q) begin
         grant_idx = lock_idx_q;
         grant_any = req_valid[lock_idx_q];
      end else begin
         for (int k = NUM_REQS - 1; k >= 0; k--) begin
            cand = {1'b0, rr_ptr_q} + (IDX_W+1)'(k);
            if (cand >= NUM_REQS_W) begin
               cand = cand - NUM_REQS_W;
            end
            if (req_valid[cand[IDX_W-1:0]]) begin
               grant_idx = cand[IDX_W-1:0];
               grant_any = 1'b1;
            end
         end
      end
   end

   always_comb begin
      wb_valid_d = wb_valid_q;
      wb_wid_d   = wb_wid_q;
      wb_tmask_d = wb_tmask_q;
      wb_pc_d    = wb_pc_q;
      wb_rd_d    = wb_rd_q;
      wb_data_d  = wb_data_q;
      wb_eop_d   = wb_eop_q;
      rr_ptr_d   = rr_ptr_q;
      lock_d     = lock_q;
      lock_idx_d = lock_idx_q;
      if (fire) begin
         if (req_wb[grant_idx]) begin
            wb_valid_d = 1'b1;
            wb_wid_d   = src_wid[grant_idx];
            wb_tmask_d = src_tmask[grant_idx];
            wb_pc_d    = src_pc[grant_idx];
            wb_rd_d    = src_rd[grant_idx];
            wb_data_d  = src_data[grant_idx];
            wb_eop_d   = req_eop[grant_idx];
         end else begin
            // A fire implies the register is empty or draining this cycle,
            // so a dropped beat always leaves it empty.
            wb_valid_d = 1'b0;
         end
         if (req_eop[grant_idx]) begin
            lock_d   = 1'b0;
            rr_ptr_d = (grant_idx == LAST_IDX) ? '0 : grant_idx + IDX_W'(1);
         end else begin
            lock_d     = 1'b1;
            lock_idx_d = grant_idx;
         end
      end else if (wb_ready) begin
         wb_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wb_valid_q <= 1'b0;
         wb_wid_q   <= '0;
         wb_tmask_q <= '0;
         wb_pc_q    <= '0;
         wb_rd_q    <= '0;
         wb_data_q  <= '0;
         wb_eop_q   <= 1'b0;
         rr_ptr_q   <= '0;
         lock_q     <= 1'b0;
         lock_idx_q <= '0;
      end else begin
         wb_valid_q <= wb_valid_d;
         wb_wid_q   <= wb_wid_d;
         wb_tmask_q <= wb_tmask_d;
         wb_pc_q    <= wb_pc_d;
         wb_rd_q    <= wb_rd_d;
         wb_data_q  <= wb_data_d;
         wb_eop_q   <= wb_eop_d;
         rr_ptr_q   <= rr_ptr_d;
         lock_q     <= lock_d;
         lock_idx_q <= lock_idx_d;
      end
   end

   assign wb_valid = wb_valid_q;
   assign wb_wid   = wb_wid_q;
   assign wb_tmask = wb_tmask_q;
   assign wb_PC    = wb_pc_q;
   assign wb_rd    = wb_rd_q;
   assign wb_data  = wb_data_q;
   assign wb_eop   = wb_eop_q;

`ifndef SYNTHESIS
   for (genvar gi = 0; gi < NUM_REQS; gi++) begin : g_chk
      a_src_stable: assert property (@(posedge clk) disable iff (!reset)
         (req_valid[gi] && !req_ready[gi]) |=>
            $stable({src_wid[gi], src_tmask[gi], src_pc[gi], src_rd[gi],
                     src_data[gi], req_wb[gi], req_eop[gi]}));
   end
   a_one_ready: assert property (@(posedge clk) disable iff (!reset)
      $onehot0(req_ready));
`endif

endmodule

// File: tb/tb_vx_commit_writeback.sv
// tb_vx_commit_writeback
//   Scoreboard bench for vx_commit_writeback. Each source is a queue of beats
//   that is presented until accepted; expected writeback beats are queued in
//   the order they must appear and compared on each wb handshake.
module tb_vx_commit_writeback;

   localparam int N  = 5;
   localparam int T  = 4;
   localparam int NW = 2;
   localparam int PW = 32;
   localparam int RB = 5;
   localparam int DW = 32;

   typedef struct packed {
      logic [NW-1:0]   wid;
      logic [T-1:0]    tmask;
      logic [PW-1:0]   pc;
      logic [RB-1:0]   rd;
      logic [T*DW-1:0] data;
      logic            eop;
   } out_t;

   typedef struct packed {
      logic wb;
      out_t o;
   } beat_t;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic [N-1:0]      req_valid = '0;
   logic [N*NW-1:0]   req_wid = '0;
   logic [N*T-1:0]    req_tmask = '0;
   logic [N*PW-1:0]   req_PC = '0;
   logic [N*RB-1:0]   req_rd = '0;
   logic [N-1:0]      req_wb = '0;
   logic [N*T*DW-1:0] req_data = '0;
   logic [N-1:0]      req_eop = '0;
   logic [N-1:0]      req_ready;
   logic              wb_valid;
   logic              wb_ready = 1'b1;
   logic [NW-1:0]     wb_wid;
   logic [T-1:0]      wb_tmask;
   logic [PW-1:0]     wb_PC;
   logic [RB-1:0]     wb_rd;
   logic [T*DW-1:0]   wb_data;
   logic              wb_eop;

   vx_commit_writeback #(
      .NUM_REQS(N), .NUM_THREADS(T), .NW_BITS(NW),
      .PC_WIDTH(PW), .RD_BITS(RB), .DATA_WIDTH(DW)
   ) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_wid(req_wid), .req_tmask(req_tmask),
      .req_PC(req_PC), .req_rd(req_rd), .req_wb(req_wb), .req_data(req_data),
      .req_eop(req_eop), .req_ready(req_ready),
      .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_wid(wb_wid),
      .wb_tmask(wb_tmask), .wb_PC(wb_PC), .wb_rd(wb_rd), .wb_data(wb_data),
      .wb_eop(wb_eop)
   );

   always #5 clk = ~clk;

   beat_t        src_q [N][$];
   out_t         exp_q [$];
   logic [N-1:0] fired = '0;
   logic [N-1:0] mute = '0;
   beat_t        drv_beat;
   out_t         wb_obs;
   out_t         exp_beat;
   int           n_cmp = 0;
   int           n_err = 0;
   int           run_len = 0;
   int           max_run = 0;

   assign wb_obs = {wb_wid, wb_tmask, wb_PC, wb_rd, wb_data, wb_eop};

   task automatic check_val(input string tag, input logic [255:0] obs,
                            input logic [255:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic beat_t mk(input logic wb, input logic [NW-1:0] wid,
                                input logic [RB-1:0] rd, input logic [31:0] d,
                                input logic eop, input logic [T-1:0] tmask);
      beat_t b;
      b.wb      = wb;
      b.o.wid   = wid;
      b.o.tmask = tmask;
      b.o.pc    = 32'h1000 + d;
      b.o.rd    = rd;
      b.o.data  = {T{d}};
      b.o.eop   = eop;
      return b;
   endfunction

   task automatic send(input int src, input beat_t b, input bit expect_out);
      src_q[src].push_back(b);
      if (expect_out && b.wb) exp_q.push_back(b.o);
   endtask

   function automatic bit all_idle();
      bit idle;
      idle = (exp_q.size() == 0) && !wb_valid;
      for (int i = 0; i < N; i++) if (src_q[i].size() != 0) idle = 0;
      return idle;
   endfunction

   task automatic wait_idle(input string tag, input int budget);
      bit idle;
      idle = 0;
      for (int c = 0; c < budget && !idle; c++) begin
         @(negedge clk);
         idle = all_idle();
      end
      check_val(tag, idle, 1);
   endtask

   task automatic set_ready(input logic v);
      @(posedge clk);
      #1 wb_ready = v;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < N; i++) src_q[i].delete();
      exp_q.delete();
      mute = '0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
   endtask

   // Source driver: retire the head accepted at the last edge, present the next.
   always @(posedge clk) begin
      #1;
      for (int i = 0; i < N; i++) begin
         if (fired[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
         if (src_q[i].size() > 0 && !mute[i]) begin
            drv_beat = src_q[i][0];
            req_valid[i]            = 1'b1;
            req_wb[i]               = drv_beat.wb;
            req_eop[i]              = drv_beat.o.eop;
            req_wid[i*NW +: NW]     = drv_beat.o.wid;
            req_tmask[i*T +: T]     = drv_beat.o.tmask;
            req_PC[i*PW +: PW]      = drv_beat.o.pc;
            req_rd[i*RB +: RB]      = drv_beat.o.rd;
            req_data[i*T*DW +: T*DW] = drv_beat.o.data;
         end else begin
            req_valid[i] = 1'b0;
         end
      end
   end

   // Monitor: record accepted source beats and score writeback beats.
   always @(negedge clk) begin
      if (!reset) begin
         fired = '0;
         run_len = 0;
      end else begin
         fired = req_valid & req_ready;
         run_len = wb_valid ? run_len + 1 : 0;
         if (run_len > max_run) max_run = run_len;
         if (wb_valid && wb_ready) begin
            if (exp_q.size() == 0) begin
               check_val("wb_unexpected", wb_obs, 0);
            end else begin
               exp_beat = exp_q.pop_front();
               check_val("wb_beat", wb_obs, exp_beat);
            end
         end
      end
   end

   initial begin
      // Reset state
      repeat (3) @(negedge clk);
      check_val("rst_wb_valid", wb_valid, 0);
      check_val("rst_payload", wb_obs, 0);
      check_val("rst_req_ready", req_ready, 0);
      check_val("rst_rr_ptr", dut.rr_ptr_q, 0);
      check_val("rst_lock", dut.lock_q, 0);
      reset = 1'b1;

      // Single ALU beat: same-cycle ready, one-cycle latency
      @(negedge clk);
      send(0, mk(1'b1, 2'd1, 5'd5, 32'h11, 1'b1, 4'hF), 1);
      @(negedge clk);
      check_val("t1_req_ready", req_ready, 5'b00001);
      check_val("t1_wb_valid_early", wb_valid, 0);
      @(negedge clk);
      check_val("t1_wb_valid", wb_valid, 1);
      check_val("t1_wb_rd", wb_rd, 5);
      check_val("t1_wb_data", wb_data, {4{32'h11}});
      check_val("t1_wb_eop", wb_eop, 1);
      check_val("t1_rr_ptr", dut.rr_ptr_q, 1);
      wait_idle("t1_idle", 20);

      // All sources valid: round-robin 0,1,2,3,4,0 back to back
      do_reset();
      @(negedge clk);
      for (int r = 0; r < 2; r++)
         for (int s = 0; s < N; s++)
            if (r == 0 || s == 0)
               send(s, mk(1'b1, NW'(s), RB'(s + 8), 32'h200 + 32'(r * 16 + s),
                          1'b1, T'(s + 1)), 1);
      wait_idle("t2_idle", 40);
      check_val("t2_back_to_back", max_run, 6);
      check_val("t2_rr_ptr", dut.rr_ptr_q, 1);

      // LSU 3-beat packet keeps the grant even while it stalls
      @(negedge clk);
      send(1, mk(1'b1, 2'd2, 5'd10, 32'h301, 1'b0, 4'hA), 1);
      send(1, mk(1'b1, 2'd2, 5'd10, 32'h302, 1'b0, 4'hA), 1);
      send(1, mk(1'b1, 2'd2, 5'd10, 32'h303, 1'b1, 4'hA), 1);
      send(0, mk(1'b1, 2'd0, 5'd11, 32'h3A0, 1'b1, 4'h5), 1);
      @(negedge clk);
      check_val("t3_lsu_first", req_ready, 5'b00010);
      mute[1] = 1'b1;
      @(negedge clk);
      check_val("t3_stall_a", req_ready, 0);
      check_val("t3_locked", dut.lock_q, 1);
      @(negedge clk);
      check_val("t3_stall_b", req_ready, 0);
      mute[1] = 1'b0;
      wait_idle("t3_idle", 40);

      // Backpressure: held beat stays stable, CSR waits
      @(negedge clk);
      send(4, mk(1'b1, 2'd3, 5'd12, 32'h4A0, 1'b1, 4'h3), 1);
      set_ready(1'b0);
      @(negedge clk);
      send(2, mk(1'b1, 2'd2, 5'd13, 32'h4B0, 1'b1, 4'hC), 1);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check_val("t4_hold_payload", wb_obs,
                   mk(1'b1, 2'd3, 5'd12, 32'h4A0, 1'b1, 4'h3).o);
         check_val("t4_hold_ready", req_ready, 0);
      end
      set_ready(1'b1);
      @(negedge clk);
      check_val("t4_csr_ready", req_ready, 5'b00100);
      @(negedge clk);
      check_val("t4_csr_valid", wb_valid, 1);
      check_val("t4_csr_rd", wb_rd, 13);
      wait_idle("t4_idle", 20);

      // FPU beat with wb=0 is consumed but never written back
      @(negedge clk);
      send(3, mk(1'b0, 2'd1, 5'd14, 32'h5A0, 1'b1, 4'hF), 0);
      @(negedge clk);
      check_val("t5_fpu_ready", req_ready, 5'b01000);
      check_val("t5_wb_valid_a", wb_valid, 0);
      @(negedge clk);
      check_val("t5_wb_valid_b", wb_valid, 0);
      check_val("t5_rr_ptr", dut.rr_ptr_q, 4);
      wait_idle("t5_idle", 20);

      // Reset in the middle of a GPU 2-beat packet
      set_ready(1'b0);
      @(negedge clk);
      send(4, mk(1'b1, 2'd0, 5'd15, 32'h6A0, 1'b0, 4'hF), 0);
      send(4, mk(1'b1, 2'd0, 5'd15, 32'h6A1, 1'b1, 4'hF), 0);
      @(negedge clk);
      check_val("t6_gpu_ready", req_ready, 5'b10000);
      @(negedge clk);
      check_val("t6_held", wb_valid, 1);
      check_val("t6_lock_set", dut.lock_q, 1);
      #2 reset = 1'b0;
      #1;
      check_val("t6_async_valid", wb_valid, 0);
      check_val("t6_async_lock", dut.lock_q, 0);
      check_val("t6_ready_in_reset", req_ready, 0);
      for (int i = 0; i < N; i++) src_q[i].delete();
      repeat (2) @(negedge clk);
      reset = 1'b1;
      wb_ready = 1'b1;
      @(negedge clk);
      send(0, mk(1'b1, 2'd1, 5'd16, 32'h7A0, 1'b1, 4'h9), 1);
      send(4, mk(1'b1, 2'd3, 5'd17, 32'h7B0, 1'b1, 4'h6), 1);
      @(negedge clk);
      check_val("t6_alu_first", req_ready, 5'b00001);
      wait_idle("t6_idle", 20);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
